// File: rtl/clock_pkg.sv
// Shared constants and BCD helpers for the clock time-field counters.
// Helpers work on up to four packed BCD digits.
package clock_pkg;

  localparam int BCD_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic int bcd_to_int(
    input logic [15:0] v,
    input int          n
  );
    int r;
    r = 0;
    for (int i = 3; i >= 0; i--) begin
      if (i < n) r = r * 10 + int'(v[4*i +: 4]);
    end
    return r;
  endfunction

  function automatic logic bcd_valid(
    input logic [15:0] v,
    input int          n
  );
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i < n && v[4*i +: 4] > BCD_MAX) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [15:0] int_to_bcd(input int x);
    logic [15:0] r;
    int          t;
    r = '0;
    t = x;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod_counter_if.sv
// Control and status bundle of one BCD range counter.
// master drives the controls, slave is the counter.
interface bcd_mod_counter_if
  import clock_pkg::*;
#(
  parameter int DIGITS = 2
);

  logic                      en;
  logic                      up_dn;
  logic                      load_en;
  logic [BCD_W*DIGITS-1:0]   load_val;
  logic [BCD_W*DIGITS-1:0]   count;
  logic                      tc;
  logic                      wrap;
  logic                      load_err;

  modport master (
    output en, up_dn, load_en, load_val,
    input  count, tc, wrap, load_err
  );

  modport slave (
    input  en, up_dn, load_en, load_val,
    output count, tc, wrap, load_err
  );

endinterface

// File: rtl/bcd_digit.sv
// One BCD digit: increment with carry and decrement with borrow.
// No range logic; the enclosing counter decides what to keep.
module bcd_digit
  import clock_pkg::*;
(
  input  logic [3:0] d,
  input  logic       ci,
  input  logic       bi,
  output logic [3:0] inc,
  output logic [3:0] dec,
  output logic       co,
  output logic       bo
);

  assign co  = ci & (d == BCD_MAX);
  assign bo  = bi & (d == 4'd0);

  assign inc = !ci ? d :
               co  ? 4'd0 :
                     d + 4'd1;

  assign dec = !bi ? d :
               bo  ? BCD_MAX :
                     d - 4'd1;

endmodule

// File: rtl/bcd_mod_counter.sv
// Multi-digit BCD counter over [MIN..MAX] with up/down, checked load,
// and registered wrap / load_err pulses.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int MIN    = 0,
  parameter int MAX    = 59
)(
  input logic             clk,
  input logic             rst,
  bcd_mod_counter_if.slave bus
);

  localparam int W = BCD_W * DIGITS;
  localparam logic [15:0] MIN_F = int_to_bcd(MIN);
  localparam logic [15:0] MAX_F = int_to_bcd(MAX);
  localparam logic [W-1:0] MIN_B = MIN_F[W-1:0];
  localparam logic [W-1:0] MAX_B = MAX_F[W-1:0];

  if (DIGITS < 1 || DIGITS > 4 || MIN < 0 ||
      MIN >= MAX || MAX >= 10**DIGITS) begin : g_bad
    $error("bcd_mod_counter: bad DIGITS/MIN/MAX");
  end

  logic [W-1:0]    count_q;
  logic [W-1:0]    nxt;
  logic [W-1:0]    inc;
  logic [W-1:0]    dec;
  logic [DIGITS:0] c;
  logic [DIGITS:0] b;
  logic            wrap_q;
  logic            err_q;
  logic            nwrap;
  logic            nerr;

  assign c[0] = 1'b1;
  assign b[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit u_dig (
      .d   (count_q[4*i +: 4]),
      .ci  (c[i]),
      .bi  (b[i]),
      .inc (inc[4*i +: 4]),
      .dec (dec[4*i +: 4]),
      .co  (c[i+1]),
      .bo  (b[i+1])
    );
  end

  // Packed compare on valid BCD orders digits MSB first, i.e. decimally.
  logic at_min, at_max, oor;
  assign at_min = (count_q == MIN_B);
  assign at_max = (count_q == MAX_B);
  assign oor    = (count_q < MIN_B) | (count_q > MAX_B);

  logic [15:0] lv16;
  int          lv_int;
  logic        load_ok;
  assign lv16    = 16'(bus.load_val);
  assign lv_int  = bcd_to_int(lv16, DIGITS);
  assign load_ok = bcd_valid(lv16, DIGITS) &&
                   lv_int >= MIN && lv_int <= MAX;

  logic step_up, step_dn;
  assign step_up = bus.en & bus.up_dn & ~bus.load_en;
  assign step_dn = bus.en & ~bus.up_dn & ~bus.load_en;

  always_comb begin
    nxt   = count_q;
    nwrap = 1'b0;
    nerr  = 1'b0;
    unique case (1'b1)
      bus.load_en: begin
        if (load_ok) nxt = bus.load_val;
        else         nerr = 1'b1;
      end
      step_up: begin
        if (at_max | oor | c[DIGITS]) begin
          nxt   = MIN_B;
          nwrap = 1'b1;
        end else begin
          nxt = inc;
        end
      end
      step_dn: begin
        if (at_min | oor | b[DIGITS]) begin
          nxt   = MAX_B;
          nwrap = 1'b1;
        end else begin
          nxt = dec;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= MIN_B;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= nxt;
      wrap_q  <= nwrap;
      err_q   <= nerr;
    end
  end

  assign bus.count    = count_q;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = err_q;
  assign bus.tc       = bus.up_dn ? at_max : at_min;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Bench for bcd_mod_counter: directed scenarios plus random traffic
// against a decimal-integer model of every instance.
module tb_bcd_mod_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bcd_mod_counter_if #(.DIGITS(2)) a_if ();
  bcd_mod_counter_if #(.DIGITS(2)) b_if ();
  bcd_mod_counter_if #(.DIGITS(3)) c_if ();
  bcd_mod_counter_if #(.DIGITS(2)) s_if ();
  bcd_mod_counter_if #(.DIGITS(2)) m_if ();

  bcd_mod_counter #(.DIGITS(2), .MIN(0), .MAX(59)) u_a (
    .clk(clk), .rst(rst), .bus(a_if));
  bcd_mod_counter #(.DIGITS(2), .MIN(1), .MAX(12)) u_b (
    .clk(clk), .rst(rst), .bus(b_if));
  bcd_mod_counter #(.DIGITS(3), .MIN(5), .MAX(250)) u_c (
    .clk(clk), .rst(rst), .bus(c_if));
  bcd_mod_counter #(.DIGITS(2), .MIN(0), .MAX(59)) u_s (
    .clk(clk), .rst(rst), .bus(s_if));
  bcd_mod_counter #(.DIGITS(2), .MIN(0), .MAX(59)) u_m (
    .clk(clk), .rst(rst), .bus(m_if));

  assign m_if.en    = s_if.tc & s_if.en;
  assign m_if.up_dn = s_if.up_dn;

  typedef struct {
    int v;
    bit w;
    bit le;
  } ms_t;

  ms_t ma = '{0, 1'b0, 1'b0};
  ms_t mb = '{1, 1'b0, 1'b0};
  ms_t mc = '{5, 1'b0, 1'b0};
  ms_t ms = '{0, 1'b0, 1'b0};
  ms_t mm = '{0, 1'b0, 1'b0};

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] seq [10] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                           8'h06, 8'h07, 8'h08, 8'h09, 8'h10};

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Decimal model: the value is a plain integer.
  function automatic ms_t mstep(input ms_t s, input bit en,
      input bit up, input bit ld, input logic [15:0] lv,
      input int nd, input int mn, input int mx);
    ms_t r;
    int val;
    bit ok;
    r = s;
    r.w = 1'b0;
    r.le = 1'b0;
    val = 0;
    ok = 1'b1;
    if (ld) begin
      for (int i = nd - 1; i >= 0; i--) begin
        int d;
        d = int'(lv[4*i +: 4]);
        if (d > 9) ok = 1'b0;
        val = val * 10 + d;
      end
      if (ok && val >= mn && val <= mx) r.v = val;
      else r.le = 1'b1;
    end else if (en) begin
      if (up) begin
        if (s.v >= mx || s.v < mn) begin
          r.v = mn;
          r.w = 1'b1;
        end else r.v = s.v + 1;
      end else begin
        if (s.v <= mn || s.v > mx) begin
          r.v = mx;
          r.w = 1'b1;
        end else r.v = s.v - 1;
      end
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input string nm, input ms_t s,
      input logic [15:0] cnt, input logic tc, input logic w,
      input logic le, input logic up, input int mn, input int mx);
    bit etc;
    etc = up ? (s.v == mx) : (s.v == mn);
    chk({nm, ".count"}, 32'(cnt), 32'(to_bcd(s.v)));
    chk({nm, ".tc"}, 32'(tc), 32'(etc));
    chk({nm, ".wrap"}, 32'(w), 32'(s.w));
    chk({nm, ".load_err"}, 32'(le), 32'(s.le));
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ma = '{0, 1'b0, 1'b0};
      mb = '{1, 1'b0, 1'b0};
      mc = '{5, 1'b0, 1'b0};
      ms = '{0, 1'b0, 1'b0};
      mm = '{0, 1'b0, 1'b0};
    end else begin
      bit men;
      men = s_if.en && (s_if.up_dn ? ms.v == 59 : ms.v == 0);
      mm = mstep(mm, men, s_if.up_dn, m_if.load_en,
                 16'(m_if.load_val), 2, 0, 59);
      ms = mstep(ms, s_if.en, s_if.up_dn, s_if.load_en,
                 16'(s_if.load_val), 2, 0, 59);
      ma = mstep(ma, a_if.en, a_if.up_dn, a_if.load_en,
                 16'(a_if.load_val), 2, 0, 59);
      mb = mstep(mb, b_if.en, b_if.up_dn, b_if.load_en,
                 16'(b_if.load_val), 2, 1, 12);
      mc = mstep(mc, c_if.en, c_if.up_dn, c_if.load_en,
                 16'(c_if.load_val), 3, 5, 250);
    end
  end

  always @(negedge clk) begin
    cmp("a", ma, 16'(a_if.count), a_if.tc, a_if.wrap,
        a_if.load_err, a_if.up_dn, 0, 59);
    cmp("b", mb, 16'(b_if.count), b_if.tc, b_if.wrap,
        b_if.load_err, b_if.up_dn, 1, 12);
    cmp("c", mc, 16'(c_if.count), c_if.tc, c_if.wrap,
        c_if.load_err, c_if.up_dn, 5, 250);
    cmp("s", ms, 16'(s_if.count), s_if.tc, s_if.wrap,
        s_if.load_err, s_if.up_dn, 0, 59);
    cmp("m", mm, 16'(m_if.count), m_if.tc, m_if.wrap,
        m_if.load_err, m_if.up_dn, 0, 59);
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [15:0] rnd_lv(input int mn, input int mx);
    if ($urandom_range(0, 1) == 1)
      return to_bcd(mn + int'($urandom_range(0, 32'(mx - mn))));
    return 16'($urandom);
  endfunction

  initial begin
    a_if.en = 0; a_if.up_dn = 1; a_if.load_en = 0; a_if.load_val = '0;
    b_if.en = 0; b_if.up_dn = 1; b_if.load_en = 0; b_if.load_val = '0;
    c_if.en = 0; c_if.up_dn = 1; c_if.load_en = 0; c_if.load_val = '0;
    s_if.en = 0; s_if.up_dn = 1; s_if.load_en = 0; s_if.load_val = '0;
    m_if.load_en = 0; m_if.load_val = '0;

    tick();
    chk("rst_a", 32'(a_if.count), 32'h00);
    chk("rst_b", 32'(b_if.count), 32'h01);
    chk("rst_c", 32'(c_if.count), 32'h005);
    rst = 1'b1;
    a_if.en = 1;

    for (int k = 0; k < 10; k++) begin
      tick();
      chk("carry_seq", 32'(a_if.count), 32'(seq[k]));
    end

    a_if.en = 0; a_if.load_en = 1; a_if.load_val = 8'h58;
    tick();
    chk("load58", 32'(a_if.count), 32'h58);
    a_if.load_en = 0; a_if.en = 1;
    tick();
    chk("up59", 32'(a_if.count), 32'h59);
    chk("up59_tc", 32'(a_if.tc), 32'h1);
    tick();
    chk("upwrap", 32'(a_if.count), 32'h00);
    chk("upwrap_w", 32'(a_if.wrap), 32'h1);
    rst = 1'b0;
    #1;
    chk("async_cnt", 32'(a_if.count), 32'h00);
    chk("async_wrap", 32'(a_if.wrap), 32'h0);
    rst = 1'b1;
    tick();
    chk("rel_cnt", 32'(a_if.count), 32'h01);
    chk("rel_wrap", 32'(a_if.wrap), 32'h0);

    a_if.up_dn = 0; a_if.load_en = 1; a_if.load_val = 8'h01;
    tick();
    chk("ld_prio", 32'(a_if.count), 32'h01);
    a_if.load_en = 0;
    tick();
    chk("dn00", 32'(a_if.count), 32'h00);
    chk("dn00_tc", 32'(a_if.tc), 32'h1);
    tick();
    chk("dnwrap", 32'(a_if.count), 32'h59);
    chk("dnwrap_w", 32'(a_if.wrap), 32'h1);
    tick();
    chk("dn58", 32'(a_if.count), 32'h58);
    chk("dn58_w", 32'(a_if.wrap), 32'h0);

    a_if.en = 0; a_if.load_en = 1; a_if.load_val = 8'h7A;
    tick();
    chk("bad7A_cnt", 32'(a_if.count), 32'h58);
    chk("bad7A_err", 32'(a_if.load_err), 32'h1);
    tick();
    chk("bad7A_err2", 32'(a_if.load_err), 32'h1);
    a_if.load_en = 0;
    tick();
    chk("err_clr", 32'(a_if.load_err), 32'h0);
    a_if.load_en = 1; a_if.load_val = 8'h60;
    tick();
    chk("bad60_err", 32'(a_if.load_err), 32'h1);
    chk("bad60_cnt", 32'(a_if.count), 32'h58);
    a_if.load_val = 8'h45; a_if.en = 1; a_if.up_dn = 1;
    tick();
    chk("ld45", 32'(a_if.count), 32'h45);
    a_if.load_en = 0; a_if.en = 0;

    b_if.load_en = 1; b_if.load_val = 8'h12;
    tick();
    chk("b12", 32'(b_if.count), 32'h12);
    b_if.load_en = 0; b_if.en = 1;
    tick();
    chk("b_wrap_cnt", 32'(b_if.count), 32'h01);
    chk("b_wrap", 32'(b_if.wrap), 32'h1);
    b_if.en = 0; b_if.load_en = 1; b_if.load_val = 8'h00;
    tick();
    chk("b00_err", 32'(b_if.load_err), 32'h1);
    chk("b00_cnt", 32'(b_if.count), 32'h01);
    b_if.load_en = 0;

    s_if.load_en = 1; s_if.load_val = 8'h59;
    m_if.load_en = 1; m_if.load_val = 8'h59;
    tick();
    chk("ch_s59", 32'(s_if.count), 32'h59);
    chk("ch_m59", 32'(m_if.count), 32'h59);
    s_if.load_en = 0; m_if.load_en = 0; s_if.en = 1;
    tick();
    chk("ch_s00", 32'(s_if.count), 32'h00);
    chk("ch_m00", 32'(m_if.count), 32'h00);
    chk("ch_sw", 32'(s_if.wrap), 32'h1);
    chk("ch_mw", 32'(m_if.wrap), 32'h1);
    s_if.en = 0;

    repeat (2000) begin
      a_if.en = 1'($urandom); a_if.up_dn = 1'($urandom);
      a_if.load_en = ($urandom_range(0, 7) == 0);
      a_if.load_val = 8'(rnd_lv(0, 59));
      b_if.en = 1'($urandom); b_if.up_dn = 1'($urandom);
      b_if.load_en = ($urandom_range(0, 7) == 0);
      b_if.load_val = 8'(rnd_lv(1, 12));
      c_if.en = 1'($urandom); c_if.up_dn = 1'($urandom);
      c_if.load_en = ($urandom_range(0, 7) == 0);
      c_if.load_val = 12'(rnd_lv(5, 250));
      s_if.en = ($urandom_range(0, 3) != 0);
      s_if.up_dn = ($urandom_range(0, 5) != 0);
      s_if.load_en = ($urandom_range(0, 15) == 0);
      s_if.load_val = 8'(rnd_lv(0, 59));
      m_if.load_en = ($urandom_range(0, 31) == 0);
      m_if.load_val = 8'(rnd_lv(0, 59));
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        #1;
        rst = 1'b1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
